// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage next-PC predictor: RVC/32-bit decode, bimodal BHT, circular RAS
module branch_predictor #(
    parameter int ALEN         = 32,
    parameter int ILEN         = 32,
    parameter int BHT_IDX_BITS = 6,
    parameter int RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [ILEN-1:0] instruction,
    input  logic [ALEN-1:0] instruction_addr,
    input  logic [ALEN-1:0] mepc,
    input  logic            upd_valid,
    input  logic [ALEN-1:0] upd_addr,
    input  logic            upd_taken,
    input  logic            ras_flush,
    output logic            should_follow_branch,
    output logic [ALEN-1:0] branch_target,
    output logic            pred_from_table
);

    localparam int ENTRIES = 1 << BHT_IDX_BITS;
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [ENTRIES-1:0] bht_valid;
    logic [1:0]         bht_ctr [ENTRIES];
    logic [ALEN-1:0]    ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   ras_ptr;
    logic [PTR_W-1:0]   ras_top;
    logic [CNT_W-1:0]   ras_count;

    logic [BHT_IDX_BITS-1:0] fetch_idx;
    logic [BHT_IDX_BITS-1:0] upd_idx;
    logic                    unused_upd_bits;

    logic [6:0] opcode;
    logic [2:0] c_funct3;
    logic [1:0] c_op;
    logic       is_rvc;
    logic       rd_link;
    logic       rs1_link;
    logic       c_rs1_link;
    logic       cond32, c_branch, jal32, c_jump, jalr32, c_jr;
    logic       is_cond, is_jal, is_xret, is_ret, is_call;
    logic       taken;
    logic [ALEN-1:0] imm_b, imm_j, imm_cb, imm_cj;
    logic [ALEN-1:0] imm_sel;
    logic [ALEN-1:0] link_addr;

    assign fetch_idx       = instruction_addr[BHT_IDX_BITS:1];
    assign upd_idx         = upd_addr[BHT_IDX_BITS:1];
    assign unused_upd_bits = ^{upd_addr[ALEN-1:BHT_IDX_BITS+1], upd_addr[0]};

    assign opcode     = instruction[6:0];
    assign c_funct3   = instruction[15:13];
    assign c_op       = instruction[1:0];
    assign is_rvc     = (instruction[1:0] != 2'b11);
    assign rd_link    = (instruction[11:7] == 5'd1) || (instruction[11:7] == 5'd5);
    assign rs1_link   = (instruction[19:15] == 5'd1) || (instruction[19:15] == 5'd5);
    assign c_rs1_link = rd_link;

    assign cond32   = !is_rvc && (opcode == OP_BRANCH);
    assign jal32    = !is_rvc && (opcode == OP_JAL);
    assign jalr32   = !is_rvc && (opcode == OP_JALR);
    assign c_branch = is_rvc && (c_op == 2'b01) && (c_funct3[2:1] == 2'b11);
    assign c_jump   = is_rvc && (c_op == 2'b01) && (c_funct3 == 3'b101);
    assign c_jr     = is_rvc && (c_op == 2'b10) && (c_funct3 == 3'b100) && !instruction[12]
                      && (instruction[6:2] == 5'd0);

    assign is_cond = cond32 || c_branch;
    assign is_jal  = jal32 || c_jump;
    // MRET/SRET: funct12 00x1000_00010 with rs1/funct3/rd all zero
    assign is_xret = !is_rvc && (opcode == OP_SYSTEM) && (instruction[19:7] == 13'd0)
                     && (instruction[31:30] == 2'b00) && (instruction[28:20] == 9'b1_0000_0010);
    assign is_ret  = (jalr32 && (instruction[11:7] == 5'd0) && (instruction[31:20] == 12'd0) && rs1_link)
                     || (c_jr && c_rs1_link);
    assign is_call = (jal32 || jalr32) && rd_link;

    assign imm_b  = {{(ALEN-12){instruction[31]}}, instruction[7], instruction[30:25],
                     instruction[11:8], 1'b0};
    assign imm_j  = {{(ALEN-20){instruction[31]}}, instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
    assign imm_cb = {{(ALEN-8){instruction[12]}}, instruction[6:5], instruction[2],
                     instruction[11:10], instruction[4:3], 1'b0};
    assign imm_cj = {{(ALEN-11){instruction[12]}}, instruction[8], instruction[10:9],
                     instruction[6], instruction[7], instruction[2], instruction[11],
                     instruction[5:3], 1'b0};

    always_comb begin
        imm_sel = '0;
        if (cond32)        imm_sel = imm_b;
        else if (c_branch) imm_sel = imm_cb;
        else if (jal32)    imm_sel = imm_j;
        else if (c_jump)   imm_sel = imm_cj;
    end

    // cold entries fall back to backward-taken via the offset sign bit
    assign taken = bht_valid[fetch_idx] ? bht_ctr[fetch_idx][1]
                                        : (is_rvc ? instruction[12] : instruction[31]);

    assign ras_top   = ras_ptr - 1'b1;
    assign link_addr = instruction_addr + ALEN'(4);

    always_comb begin
        if (is_xret)     branch_target = mepc;
        else if (is_ret) branch_target = ras_mem[ras_top];
        else             branch_target = instruction_addr + imm_sel;
    end

    assign should_follow_branch = instr_valid && (is_jal || is_xret || (is_cond && taken)
                                  || (is_ret && (ras_count != '0)));
    assign pred_from_table = instr_valid && is_cond && bht_valid[fetch_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            bht_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) bht_ctr[i] <= 2'b01;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
            ras_ptr   <= '0;
            ras_count <= '0;
        end else begin
            if (upd_valid) begin
                if (!bht_valid[upd_idx]) begin
                    bht_valid[upd_idx] <= 1'b1;
                    bht_ctr[upd_idx]   <= upd_taken ? 2'b10 : 2'b01;
                end else if (upd_taken && (bht_ctr[upd_idx] != 2'b11)) begin
                    bht_ctr[upd_idx] <= bht_ctr[upd_idx] + 2'd1;
                end else if (!upd_taken && (bht_ctr[upd_idx] != 2'b00)) begin
                    bht_ctr[upd_idx] <= bht_ctr[upd_idx] - 2'd1;
                end
            end

            if (ras_flush) begin
                ras_ptr   <= '0;
                ras_count <= '0;
            end else if (instr_valid) begin
                // pop-then-push on a non-empty stack just replaces the top entry
                if (is_call && is_ret && (ras_count != '0)) begin
                    ras_mem[ras_top] <= link_addr;
                end else if (is_call) begin
                    ras_mem[ras_ptr] <= link_addr;
                    ras_ptr          <= ras_ptr + 1'b1;
                    if (ras_count != RAS_FULL) ras_count <= ras_count + 1'b1;
                end else if (is_ret && (ras_count != '0)) begin
                    ras_ptr   <= ras_top;
                    ras_count <= ras_count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor against a queue/array model
module tb_branch_predictor;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_addr;
    logic [31:0] mepc;
    logic        upd_valid;
    logic [31:0] upd_addr;
    logic        upd_taken;
    logic        ras_flush;
    logic        should_follow_branch;
    logic [31:0] branch_target;
    logic        pred_from_table;

    always #5 clk = ~clk;

    branch_predictor #(
        .ALEN(32), .ILEN(32), .BHT_IDX_BITS(6), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
        .instruction_addr(instruction_addr), .mepc(mepc), .upd_valid(upd_valid),
        .upd_addr(upd_addr), .upd_taken(upd_taken), .ras_flush(ras_flush),
        .should_follow_branch(should_follow_branch), .branch_target(branch_target),
        .pred_from_table(pred_from_table)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    typedef enum int {K_NONE, K_COND, K_JAL, K_XRET, K_RET} kind_t;
    kind_t       m_kind;
    logic [31:0] m_off;
    bit          m_call;
    bit          mv [64];
    int          mc [64];
    logic [31:0] rq [$];

    function automatic bit is_link(input int r);
        return (r == 1) || (r == 5);
    endfunction

    function automatic logic [31:0] rand_off(input int bits);
        logic signed [31:0] t;
        t = ($urandom & ((32'd1 << bits) - 1) & ~32'd1) << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] o);
        return {o[12], o[10:5], 5'($urandom), 5'($urandom), 3'($urandom), o[4:1], o[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, input logic [31:0] o);
        return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_jalr(input int rd, input int rs1, input logic [11:0] imm);
        return {imm, 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [31:0] o, input bit bnez);
        return {16'($urandom), 2'b11, bnez, o[8], o[4:3], 3'($urandom), o[7:6], o[2:1], o[5], 2'b01};
    endfunction
    function automatic logic [31:0] enc_cj(input logic [31:0] o);
        return {16'($urandom), 3'b101, o[11], o[4], o[9:8], o[10], o[6], o[7], o[3:1], o[5], 2'b01};
    endfunction
    function automatic logic [31:0] enc_cjr(input int rs1);
        return {16'($urandom), 3'b100, 1'b0, 5'(rs1), 5'b00000, 2'b10};
    endfunction

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] ins, input kind_t k,
                             input logic [31:0] off, input bit call);
        instr_valid      = 1'b1;
        instruction      = ins;
        instruction_addr = pc;
        m_kind           = k;
        m_off            = off;
        m_call           = call;
    endtask

    task automatic set_idle();
        set_instr(32'h0, 32'h00000013, K_NONE, 32'h0, 1'b0);
        instr_valid = 1'b0;
    endtask

    task automatic set_cond32(input logic [31:0] pc, input logic [31:0] off);
        set_instr(pc, enc_b(off), K_COND, off, 1'b0);
    endtask
    task automatic set_jal(input logic [31:0] pc, input int rd, input logic [31:0] off);
        set_instr(pc, enc_j(rd, off), K_JAL, off, is_link(rd));
    endtask
    task automatic set_jalr(input logic [31:0] pc, input int rd, input int rs1, input logic [11:0] imm);
        kind_t k;
        k = (rd == 0 && imm == 12'd0 && is_link(rs1)) ? K_RET : K_NONE;
        set_instr(pc, enc_jalr(rd, rs1, imm), k, 32'h0, is_link(rd));
    endtask

    // compare outputs against the model for the inputs currently applied
    task automatic settle();
        bit          ef, ep;
        logic [31:0] et;
        int          ix;
        #1;
        ef = 1'b0; ep = 1'b0; et = 32'h0;
        ix = int'(instruction_addr[6:1]);
        if (instr_valid) begin
            case (m_kind)
                K_COND: begin
                    ep = mv[ix];
                    ef = mv[ix] ? (mc[ix] >= 2) : m_off[31];
                    et = instruction_addr + m_off;
                end
                K_JAL: begin
                    ef = 1'b1;
                    et = instruction_addr + m_off;
                end
                K_XRET: begin
                    ef = 1'b1;
                    et = mepc;
                end
                K_RET: begin
                    if (rq.size() > 0) begin
                        ef = 1'b1;
                        et = rq[$];
                    end
                end
                default: ;
            endcase
            check("tgt_known", 32'($isunknown(branch_target)), 32'h0);
        end
        check("follow", 32'(should_follow_branch), 32'(ef));
        check("pft", 32'(pred_from_table), 32'(ep));
        if (ef) check("target", branch_target, et);
    endtask

    task automatic advance();
        int ix;
        @(posedge clk);
        if (!rst) begin
            foreach (mv[i]) begin
                mv[i] = 1'b0;
                mc[i] = 1;
            end
            rq.delete();
        end else begin
            if (upd_valid) begin
                ix = int'(upd_addr[6:1]);
                if (!mv[ix]) begin
                    mv[ix] = 1'b1;
                    mc[ix] = upd_taken ? 2 : 1;
                end else if (upd_taken) begin
                    mc[ix] = (mc[ix] == 3) ? 3 : mc[ix] + 1;
                end else begin
                    mc[ix] = (mc[ix] == 0) ? 0 : mc[ix] - 1;
                end
            end
            if (ras_flush) rq.delete();
            else if (instr_valid) begin
                if (m_kind == K_RET && rq.size() > 0) void'(rq.pop_back());
                if (m_call) begin
                    rq.push_back(instruction_addr + 32'd4);
                    if (rq.size() > DEPTH) void'(rq.pop_front());
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic train(input logic [31:0] a, input bit t, input int n);
        set_idle();
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_taken = t;
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        int          r;
        rst = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0;
        ras_flush = 1'b0; mepc = 32'h0;
        set_idle();
        advance();
        advance();

        // outputs stay live while reset is held
        set_cond32(32'h1000, -32'sd16);
        settle();
        check("rst_bwd_follow", 32'(should_follow_branch), 32'h1);
        check("rst_bwd_target", branch_target, 32'h0FF0);
        check("rst_bwd_pft", 32'(pred_from_table), 32'h0);
        advance();
        rst = 1'b1;

        set_cond32(32'h1000, 32'sd16);
        settle();
        check("fwd_cold_follow", 32'(should_follow_branch), 32'h0);
        advance();

        train(32'h1000, 1'b0, 2);
        set_cond32(32'h1000, -32'sd16);
        settle();
        check("nt_follow", 32'(should_follow_branch), 32'h0);
        check("nt_pft", 32'(pred_from_table), 32'h1);
        advance();

        train(32'h1000, 1'b1, 2);
        set_cond32(32'h1000, -32'sd16);
        settle();
        check("t_follow", 32'(should_follow_branch), 32'h1);
        advance();
        train(32'h1000, 1'b1, 2);
        set_cond32(32'h1000, -32'sd16);
        settle();
        check("sat_follow", 32'(should_follow_branch), 32'h1);
        advance();
        train(32'h1000, 1'b0, 2);
        set_cond32(32'h1000, -32'sd16);
        settle();
        check("desat_follow", 32'(should_follow_branch), 32'h0);
        advance();

        set_jal(32'h2000, 1, 32'h100);
        settle();
        check("call_target", branch_target, 32'h2100);
        advance();
        set_jalr(32'h2100, 0, 1, 12'h0);
        settle();
        check("ret_target", branch_target, 32'h2004);
        check("ret_follow", 32'(should_follow_branch), 32'h1);
        advance();
        set_jalr(32'h2100, 0, 1, 12'h0);
        settle();
        check("ret_empty", 32'(should_follow_branch), 32'h0);
        advance();

        for (int k = 1; k <= 5; k++) begin
            set_jal(32'(k * 16), 1, 32'h100);
            settle();
            advance();
        end
        for (int k = 0; k < 5; k++) begin
            set_jalr(32'h3000, 0, 5, 12'h0);
            settle();
            if (k < 4) check("ovf_ret_target", branch_target, 32'h54 - 32'(k * 16));
            else       check("ovf_ret_empty", 32'(should_follow_branch), 32'h0);
            advance();
        end

        set_jal(32'h2000, 1, 32'h100);
        settle();
        advance();
        set_jal(32'h2200, 5, 32'h100);
        ras_flush = 1'b1;
        settle();
        advance();
        ras_flush = 1'b0;
        set_jalr(32'h2300, 0, 1, 12'h0);
        settle();
        check("flush_ret", 32'(should_follow_branch), 32'h0);
        advance();

        mepc = 32'h8000;
        set_instr(32'h4000, 32'h30200073, K_XRET, 32'h0, 1'b0);
        settle();
        check("xret_target", branch_target, 32'h8000);
        check("xret_follow", 32'(should_follow_branch), 32'h1);
        advance();

        train(32'h1000, 1'b0, 3);
        set_idle();
        upd_valid = 1'b1; upd_addr = 32'h1000; upd_taken = 1'b0;
        rst = 1'b0;
        settle();
        advance();
        rst = 1'b1; upd_valid = 1'b0;
        set_cond32(32'h1000, -32'sd16);
        settle();
        check("post_rst_pft", 32'(pred_from_table), 32'h0);
        check("post_rst_follow", 32'(should_follow_branch), 32'h1);
        advance();

        for (int n = 0; n < 3000; n++) begin
            pc = 32'h1000 + 32'(2 * $urandom_range(0, 127));
            r  = int'($urandom_range(0, 9));
            case (r)
                0: set_instr(pc, ($urandom_range(0, 1) == 0) ? 32'h12345037 : 32'h00000001,
                             K_NONE, 32'h0, 1'b0);
                1, 2: set_cond32(pc, rand_off(13));
                3: begin
                    m_off = rand_off(9);
                    set_instr(pc, enc_cb(m_off, 1'($urandom)), K_COND, m_off, 1'b0);
                end
                4: set_jal(pc, ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 5),
                           rand_off(21));
                5: begin
                    m_off = rand_off(12);
                    set_instr(pc, enc_cj(m_off), K_JAL, m_off, 1'b0);
                end
                6: set_jalr(pc, 0, ($urandom_range(0, 3) == 0) ? 2 : 1,
                            ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h0);
                7: set_jalr(pc, ($urandom_range(0, 1) == 0) ? 1 : 5, int'($urandom_range(1, 31)),
                            12'($urandom));
                8: begin
                    int rs;
                    rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 5;
                    set_instr(pc, enc_cjr(rs), is_link(rs) ? K_RET : K_NONE, 32'h0, 1'b0);
                end
                default: set_instr(pc, ($urandom_range(0, 1) == 0) ? 32'h30200073 : 32'h10200073,
                                   K_XRET, 32'h0, 1'b0);
            endcase
            instr_valid = ($urandom_range(0, 7) != 0);
            upd_valid   = ($urandom_range(0, 1) == 0);
            upd_addr    = 32'h1000 + 32'(2 * $urandom_range(0, 127));
            upd_taken   = 1'($urandom);
            ras_flush   = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 299) != 0);
            mepc        = $urandom;
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
